// File: rtl/hypipe_pkg.sv
// rtl/hypipe_pkg.sv - shared constants, beat layout and FSM encoding for the egress deparser
package hypipe_pkg;

  localparam int PKT_W  = 134;
  localparam int META_W = 128;

  // Beat tag values carried in bits [133:132]
  localparam logic [1:0] TAG_BODY   = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  // Metadata field positions
  localparam int META_DST_HI   = 127;
  localparam int META_DST_LO   = 80;
  localparam int META_SRC_HI   = 79;
  localparam int META_SRC_LO   = 32;
  localparam int META_DROP_BIT = 31;
  localparam int META_RW_BIT   = 30;

  // Deparser FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic [1:0]   tag;
    logic [3:0]   vld;
    logic [127:0] data;
  } beat_t;

  // Tail and single beats both close a packet
  function automatic logic is_last(input logic [1:0] tag);
    return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
  endfunction

  // Head and single beats both carry the Ethernet header
  function automatic logic is_first(input logic [1:0] tag);
    return (tag == TAG_HEAD) || (tag == TAG_SINGLE);
  endfunction

endpackage

// File: rtl/hypipe_egress_deparser_if.sv
// rtl/hypipe_egress_deparser_if.sv - packet/meta input and data output bundle of the egress deparser
interface hypipe_egress_deparser_if;
  import hypipe_pkg::*;

  logic              i_pkt_valid;
  logic [PKT_W-1:0]  i_pkt;
  logic              i_meta_valid;
  logic [META_W-1:0] i_meta;
  logic              o_data_valid;
  logic [PKT_W-1:0]  o_data;
  logic              o_pkt_alf;
  logic              o_overflow;

  // Upstream pipeline side: drives beats and metadata, observes output
  modport master (
    output i_pkt_valid, i_pkt, i_meta_valid, i_meta,
    input  o_data_valid, o_data, o_pkt_alf, o_overflow
  );

  // Deparser side
  modport slave (
    input  i_pkt_valid, i_pkt, i_meta_valid, i_meta,
    output o_data_valid, o_data, o_pkt_alf, o_overflow
  );

endinterface

// File: rtl/egress_sync_fifo.sv
// rtl/egress_sync_fifo.sv - show-ahead synchronous FIFO with full flag and occupancy count
module egress_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic [AW:0]  used
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot for a write
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign used    = cnt;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (cnt != '0);
  assign rd_data = mem[rd_ptr];

  // Storage array, written only when the write is accepted
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hypipe_egress_deparser.sv
// rtl/hypipe_egress_deparser.sv - egress deparser: MAC rewrite or drop per packet; optional counters under HYPIPE_EGRESS_STATS_EN
module hypipe_egress_deparser
  import hypipe_pkg::*;
#(
  parameter int PKT_AW         = 9,
  parameter int META_AW        = 4,
  parameter int PKT_ALF_MARGIN = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  hypipe_egress_deparser_if.slave   bus
`ifdef HYPIPE_EGRESS_STATS_EN
  ,
  output logic [31:0]               o_pkt_cnt,
  output logic [31:0]               o_drop_cnt
`endif
);

  localparam int PKT_DEPTH = 1 << PKT_AW;

  logic [PKT_AW:0]   pkt_used;
  logic              pkt_full;
  logic              pkt_empty;
  logic [PKT_W-1:0]  pkt_head_raw;
  logic              pkt_pop;
  logic [META_AW:0]  meta_used;
  logic              meta_full;
  logic              meta_empty;
  logic [META_W-1:0] meta_head;
  logic              meta_pop;

  logic [1:0]        state;
  logic [47:0]       dst_mac;
  logic [47:0]       src_mac;
  logic              rewrite_en;

  beat_t             head;
  beat_t             out_beat;
  logic              head_last;
  logic [PKT_AW:0]   pkt_free;

  logic              data_valid_q;
  logic [PKT_W-1:0]  data_q;
  logic              pkt_alf_q;
  logic              overflow_q;

  egress_sync_fifo #(.W(PKT_W), .AW(PKT_AW)) u_pkt_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (bus.i_pkt_valid),
    .wr_data (bus.i_pkt),
    .rd_en   (pkt_pop),
    .rd_data (pkt_head_raw),
    .full    (pkt_full),
    .used    (pkt_used)
  );

  egress_sync_fifo #(.W(META_W), .AW(META_AW)) u_meta_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (bus.i_meta_valid),
    .wr_data (bus.i_meta),
    .rd_en   (meta_pop),
    .rd_data (meta_head),
    .full    (meta_full),
    .used    (meta_used)
  );

  assign pkt_empty  = (pkt_used == '0);
  assign meta_empty = (meta_used == '0);
  assign head       = beat_t'(pkt_head_raw);
  assign head_last  = is_last(head.tag);
  assign pkt_free   = (PKT_AW+1)'(PKT_DEPTH) - pkt_used;

  // FIFO pops: meta only from IDLE once a beat is waiting too; beats only while inside a packet
  always_comb begin
    pkt_pop  = 1'b0;
    meta_pop = 1'b0;
    case (state)
      ST_IDLE:          meta_pop = !meta_empty && !pkt_empty;
      ST_SEND, ST_DROP: pkt_pop  = !pkt_empty;
      default:          ;
    endcase
  end

  // Output beat: MAC fields replaced only on a header-carrying beat of a rewrite packet
  always_comb begin
    out_beat = head;
    if (rewrite_en && is_first(head.tag)) begin
      out_beat.data[127:80] = dst_mac;
      out_beat.data[79:32]  = src_mac;
    end
  end

  // Packet FSM and per-packet metadata latch; drop wins over rewrite_en
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      dst_mac    <= '0;
      src_mac    <= '0;
      rewrite_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (meta_pop) begin
            dst_mac    <= meta_head[META_DST_HI:META_DST_LO];
            src_mac    <= meta_head[META_SRC_HI:META_SRC_LO];
            rewrite_en <= meta_head[META_RW_BIT];
            state      <= meta_head[META_DROP_BIT] ? ST_DROP : ST_SEND;
          end
        end
        ST_SEND, ST_DROP: begin
          if (pkt_pop && head_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered output stream; data holds its last value between beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      data_valid_q <= (state == ST_SEND) && pkt_pop;
      if ((state == ST_SEND) && pkt_pop) begin
        data_q <= out_beat;
      end
    end
  end

  // Almost-full (one cycle behind occupancy) and sticky overflow on any rejected write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_alf_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pkt_alf_q <= (pkt_free < (PKT_AW+1)'(PKT_ALF_MARGIN));
      if ((bus.i_pkt_valid && pkt_full) || (bus.i_meta_valid && meta_full)) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef HYPIPE_EGRESS_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;

  // Packet counters, bumped when the closing beat of a packet leaves the FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if ((state == ST_SEND) && pkt_pop && head_last) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if ((state == ST_DROP) && pkt_pop && head_last) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign o_pkt_cnt  = pkt_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

  assign bus.o_data_valid = data_valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_pkt_alf    = pkt_alf_q;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_hypipe_egress_deparser.sv
// tb/tb_hypipe_egress_deparser.sv - self-checking bench for hypipe_egress_deparser (HYPIPE_EGRESS_STATS_EN optional)
module tb_hypipe_egress_deparser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hypipe_egress_deparser_if bus ();

`ifdef HYPIPE_EGRESS_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;
`endif

  hypipe_egress_deparser dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef HYPIPE_EGRESS_STATS_EN
    ,
    .o_pkt_cnt  (pkt_cnt),
    .o_drop_cnt (drop_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int exp_pkts  = 0;
  int exp_drops = 0;

  logic [133:0] got[$];
  int           got_cyc[$];
  logic [133:0] exp_q[$];
  logic [133:0] cur[$];
  logic [133:0] pend_b[$];
  logic [127:0] pend_m[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_data_valid === 1'b1) begin
      got.push_back(bus.o_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_pkt_valid  = 1'b0;
    bus.i_meta_valid = 1'b0;
  endtask

  task automatic put_beat(input logic [133:0] b);
    bus.i_pkt_valid = 1'b1;
    bus.i_pkt       = b;
    tick();
  endtask

  task automatic put_meta(input logic [127:0] m);
    bus.i_meta_valid = 1'b1;
    bus.i_meta       = m;
    tick();
  endtask

  // Build a well-formed packet of len beats with random payload into cur
  task automatic build_pkt(input int len);
    logic [1:0] tag;
    cur.delete();
    for (int i = 0; i < len; i++) begin
      if (len == 1)          tag = 2'b11;
      else if (i == 0)       tag = 2'b01;
      else if (i == len - 1) tag = 2'b10;
      else                   tag = 2'b00;
      cur.push_back({tag, 4'($urandom), $urandom, $urandom, $urandom, $urandom});
    end
  endtask

  function automatic logic [133:0] expect_beat(input logic [133:0] b, input logic [127:0] m, input bit first);
    logic [1:0] tag;
    tag = b[133:132];
    if (first && m[30] && (tag == 2'b01 || tag == 2'b11))
      return {b[133:128], m[127:80], m[79:32], b[31:0]};
    return b;
  endfunction

  // Reference: a dropped packet vanishes, otherwise all beats emitted with the header rewrite rule
  task automatic model_pkt(input logic [127:0] m);
    if (m[31]) begin
      exp_drops++;
    end else begin
      exp_pkts++;
      foreach (cur[i]) exp_q.push_back(expect_beat(cur[i], m, i == 0));
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (got.size() < exp_q.size() && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 134'(got.size()), 134'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic clear_q();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_stats(input string tag);
`ifdef HYPIPE_EGRESS_STATS_EN
    check({tag, "_pkt_cnt"},  134'(pkt_cnt),  134'(exp_pkts));
    check({tag, "_drop_cnt"}, 134'(drop_cnt), 134'(exp_drops));
`else
    check({tag, "_no_stray_out"}, 134'(got.size()), 134'(exp_q.size()));
`endif
  endtask

  initial begin
    logic [127:0] m;
    int lat;
    int seen;

    bus.i_pkt_valid  = 1'b0;
    bus.i_pkt        = '0;
    bus.i_meta_valid = 1'b0;
    bus.i_meta       = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid",    134'(bus.o_data_valid), 134'(0));
    check("rst_data",     bus.o_data,             134'(0));
    check("rst_alf",      134'(bus.o_pkt_alf),    134'(0));
    check("rst_overflow", 134'(bus.o_overflow),   134'(0));
    check_stats("rst");

    // 3-beat packet with MAC rewrite, meta arrives after the beats are buffered
    build_pkt(3);
    foreach (cur[i]) put_beat(cur[i]);
    tick();
    tick();
    m = {48'h0A0B0C0D0E0F, 48'h111213141516, 1'b0, 1'b1, 30'h0};
    model_pkt(m);
    put_meta(m);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.o_data_valid === 1'b1) break;
    end
    check("t1_latency", 134'(lat), 134'(3));
    drain("t1");
    if (got.size() == 3) begin
      check("t1_macs",   134'(got[0][127:32]), 134'(96'h0A0B0C0D0E0F_111213141516));
      check("t1_b2b",    134'(got_cyc[2] - got_cyc[0]), 134'(2));
    end
    check_stats("t1");
    clear_q();

    // Dropped single-beat packet followed by an unmodified 2-beat packet
    build_pkt(1);
    put_beat(cur[0]);
    m = {$urandom, $urandom, $urandom, $urandom};
    m[31] = 1'b1;
    m[30] = 1'b1;
    model_pkt(m);
    put_meta(m);
    build_pkt(2);
    foreach (cur[i]) put_beat(cur[i]);
    m = {$urandom, $urandom, $urandom, $urandom};
    m[31] = 1'b0;
    m[30] = 1'b0;
    model_pkt(m);
    put_meta(m);
    drain("t2");
    check_stats("t2");
    clear_q();

    // Meta first, then beats separated by 2-cycle gaps
    build_pkt(4);
    m = {$urandom, $urandom, $urandom, $urandom};
    m[31] = 1'b0;
    m[30] = 1'b1;
    model_pkt(m);
    put_meta(m);
    tick();
    foreach (cur[i]) begin
      put_beat(cur[i]);
      tick();
      tick();
    end
    drain("t3");
    if (got.size() == 4) check("t3_stalled", 134'(got_cyc[3] - got_cyc[0] > 3), 134'(1));
    clear_q();

    // Randomised packets with interleaved beat/meta arrival
    for (int p = 0; p < 12; p++) begin
      build_pkt($urandom_range(1, 5));
      m = {$urandom, $urandom, $urandom, $urandom};
      m[31] = ($urandom_range(0, 3) == 0);
      m[30] = $urandom_range(0, 1);
      model_pkt(m);
      foreach (cur[i]) pend_b.push_back(cur[i]);
      pend_m.push_back(m);
    end
    while (pend_b.size() > 0 || pend_m.size() > 0) begin
      if (pend_b.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt       = pend_b.pop_front();
      end
      if (pend_m.size() > 0 && $urandom_range(0, 3) == 0) begin
        bus.i_meta_valid = 1'b1;
        bus.i_meta       = pend_m.pop_front();
      end
      tick();
    end
    drain("rnd");
    check_stats("rnd");
    check("rnd_no_overflow", 134'(bus.o_overflow), 134'(0));
    clear_q();

    // Fill the packet FIFO with no meta: almost-full threshold and overflow on beat 513
    for (int i = 0; i < 480; i++) put_beat({2'b00, 4'hF, 128'(i)});
    tick();
    @(negedge clk);
    check("alf_at_480", 134'(bus.o_pkt_alf), 134'(0));
    put_beat({2'b00, 4'hF, 128'(480)});
    tick();
    @(negedge clk);
    check("alf_at_481", 134'(bus.o_pkt_alf), 134'(1));
    for (int i = 481; i < 512; i++) put_beat({2'b00, 4'hF, 128'(i)});
    @(negedge clk);
    check("ovf_at_512", 134'(bus.o_overflow), 134'(0));
    put_beat({2'b00, 4'hF, 128'(512)});
    @(negedge clk);
    check("ovf_at_513", 134'(bus.o_overflow), 134'(1));
    repeat (3) tick();
    @(negedge clk);
    check("ovf_sticky", 134'(bus.o_overflow), 134'(1));
    check("fill_no_out", 134'(got.size()), 134'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pkts  = 0;
    exp_drops = 0;
    @(negedge clk);
    check("ovf_cleared", 134'(bus.o_overflow), 134'(0));
    tick();
    @(negedge clk);
    check("alf_cleared", 134'(bus.o_pkt_alf), 134'(0));
    clear_q();

    // Reset pulse during beat 2 of a 4-beat packet, then a clean packet
    build_pkt(4);
    put_meta({$urandom, $urandom, $urandom, 1'b0, 1'b1, 30'h0});
    foreach (cur[i]) put_beat(cur[i]);
    seen = 0;
    for (int k = 0; k < 30 && seen < 2; k++) begin
      @(negedge clk);
      if (bus.o_data_valid === 1'b1) seen++;
    end
    check("t5_reached_beat2", 134'(seen), 134'(2));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid_zero", 134'(bus.o_data_valid), 134'(0));
    check("t5_data_zero",  bus.o_data,             134'(0));
    clear_q();
    exp_pkts  = 0;
    exp_drops = 0;
    build_pkt(3);
    m = {$urandom, $urandom, $urandom, $urandom};
    m[31] = 1'b0;
    m[30] = 1'b1;
    model_pkt(m);
    foreach (cur[i]) put_beat(cur[i]);
    put_meta(m);
    drain("t5");
    check_stats("t5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
